// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports and one write port.
// After reset a sequencer sweeps every entry to zero before raising Ready.
module reg_file_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [AW-1:0]    Rs,
    input  logic [AW-1:0]    Rt,
    input  logic [AW-1:0]    Rd,
    input  logic             RegDst,
    input  logic             RegWr,
    input  logic             Overflow,
    input  logic             Run,
    input  logic [WIDTH-1:0] busW,
    output logic [WIDTH-1:0] busA,
    output logic [WIDTH-1:0] busB,
    output logic             Ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;
    logic             w_clear_en;
    logic             w_ready;
    logic [AW-1:0]    w_rw;
    logic             w_real_wr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_clear_en   = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clear_en = 1'b1;
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_next = READY;
                end else begin
                    w_ptr_next = r_ptr + AW'(1);
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    assign w_ready   = (r_state == READY);
    assign Ready     = w_ready;
    assign w_rw      = RegDst ? Rd : Rt;
    assign w_real_wr = RegWr & ~Overflow & Run & w_ready & ~(ZERO_REG & (w_rw == '0));

    // The array itself has no reset; the sweep is the only way it gets cleared.
    always_ff @(posedge Clk) begin
        if (Rst_n && w_clear_en) begin
            r_mem[r_ptr] <= '0;
        end else if (w_real_wr) begin
            r_mem[w_rw] <= busW;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        if (!Run || !w_ready) begin
            v = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            v = '0;
        end else if (BYPASS && w_real_wr && (w_rw == addr)) begin
            v = busW;
        end else begin
            v = r_mem[addr];
        end
        return v;
    endfunction

    always_comb begin
        busA = read_port(Rs);
        busB = read_port(Rt);
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three parameter variants share one stimulus stream
// and are compared against an array-based reference model of the register file.
module tb_reg_file_param;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NI    = 3;

    logic             Clk;
    logic             Rst_n;
    logic [AW-1:0]    Rs;
    logic [AW-1:0]    Rt;
    logic [AW-1:0]    Rd;
    logic             RegDst;
    logic             RegWr;
    logic             Overflow;
    logic             Run;
    logic [WIDTH-1:0] busW;
    logic [WIDTH-1:0] busA_o [NI];
    logic [WIDTH-1:0] busB_o [NI];
    logic             ready_o [NI];

    // instance 0: defaults, 1: no bypass, 2: hardwired zero register
    bit zr [NI] = '{1'b0, 1'b0, 1'b1};
    bit bp [NI] = '{1'b1, 1'b0, 1'b1};

    int unsigned vectors;
    int unsigned miscompares;

    logic [WIDTH-1:0] m_mem [NI][DEPTH];
    logic             m_ready;
    int unsigned      m_cnt;

    reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegDst(RegDst),
        .RegWr(RegWr), .Overflow(Overflow), .Run(Run), .busW(busW),
        .busA(busA_o[0]), .busB(busB_o[0]), .Ready(ready_o[0]));

    reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegDst(RegDst),
        .RegWr(RegWr), .Overflow(Overflow), .Run(Run), .busW(busW),
        .busA(busA_o[1]), .busB(busB_o[1]), .Ready(ready_o[1]));

    reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegDst(RegDst),
        .RegWr(RegWr), .Overflow(Overflow), .Run(Run), .busW(busW),
        .busA(busA_o[2]), .busB(busB_o[2]), .Ready(ready_o[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic m_wr(input int unsigned i);
        logic [AW-1:0] rw;
        rw = RegDst ? Rd : Rt;
        return RegWr && !Overflow && Run && m_ready && !(zr[i] && rw == '0);
    endfunction

    function automatic logic [WIDTH-1:0] m_rd(input int unsigned i, input logic [AW-1:0] a);
        logic [AW-1:0] rw;
        rw = RegDst ? Rd : Rt;
        if (!Run || !m_ready) return '0;
        if (zr[i] && a == '0) return '0;
        if (bp[i] && m_wr(i) && rw == a) return busW;
        return m_mem[i][a];
    endfunction

    // One clock edge: apply writes decided by pre-edge inputs, then advance the sweep count.
    task automatic tick();
        logic          wr [NI];
        logic [AW-1:0] rw;
        logic [WIDTH-1:0] d;
        rw = RegDst ? Rd : Rt;
        d  = busW;
        for (int unsigned i = 0; i < NI; i++) wr[i] = m_wr(i);
        @(posedge Clk);
        for (int unsigned i = 0; i < NI; i++) if (wr[i]) m_mem[i][rw] = d;
        if (!Rst_n) begin
            m_cnt   = 0;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int unsigned i = 0; i < NI; i++)
                    for (int unsigned a = 0; a < DEPTH; a++) m_mem[i][a] = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Run = 1'b1; RegWr = 1'b0; Overflow = 1'b0; Rs = 5'd3; Rt = 5'd4;
        Rst_n = 1'b0;
        tick();
        tick();
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (ready_o[i] !== 1'b0 || busA_o[i] !== '0 || busB_o[i] !== '0) begin
                miscompares++;
                $display("FAIL reset_state inst%0d: Ready=%b busA=%h busB=%h, required Ready=0 buses=0",
                         i, ready_o[i], busA_o[i], busB_o[i]);
            end
        end
        Rst_n = 1'b1;
        for (int unsigned e = 1; e <= DEPTH; e++) begin
            tick();
            for (int unsigned i = 0; i < NI; i++) begin
                vectors++;
                if (ready_o[i] !== (e == DEPTH)) begin
                    miscompares++;
                    $display("FAIL sweep_ready inst%0d edge %0d: Ready=%b, required %b",
                             i, e, ready_o[i], (e == DEPTH));
                end
            end
        end
        for (int unsigned a = 0; a < DEPTH; a++) begin
            Rs = AW'(a);
            #1;
            for (int unsigned i = 0; i < NI; i++) begin
                vectors++;
                if (busA_o[i] !== '0) begin
                    miscompares++;
                    $display("FAIL sweep_zero inst%0d r%0d: busA=%h, required 0", i, a, busA_o[i]);
                end
            end
        end
    endtask

    task automatic test_write_readback();
        Run = 1'b1; Overflow = 1'b0; RegDst = 1'b1; Rd = 5'd5; Rt = 5'd5; Rs = 5'd3;
        busW = 32'hDEADBEEF; RegWr = 1'b1;
        #1;
        vectors++;
        if (busB_o[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_on busB=%h, required deadbeef", busB_o[0]);
        end
        vectors++;
        if (busB_o[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_off busB=%h, required 0", busB_o[1]);
        end
        tick();
        RegWr = 1'b0; Rs = 5'd5; busW = 32'h0;
        #1;
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (busA_o[i] !== 32'hDEADBEEF) begin
                miscompares++;
                $display("FAIL readback inst%0d busA=%h, required deadbeef", i, busA_o[i]);
            end
        end
    endtask

    task automatic test_suppress();
        RegDst = 1'b0; Rt = 5'd7; Rs = 5'd7; busW = 32'h1234; RegWr = 1'b1;
        Overflow = 1'b1; Run = 1'b1;
        #1;
        tick();
        RegWr = 1'b0; Overflow = 1'b0;
        #1;
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (busA_o[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL overflow_suppress inst%0d r7=%h, required 0", i, busA_o[i]);
            end
        end
        RegWr = 1'b1; Run = 1'b0;
        #1;
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (busA_o[i] !== '0 || busB_o[i] !== '0) begin
                miscompares++;
                $display("FAIL run_low_reads inst%0d busA=%h busB=%h, required 0",
                         i, busA_o[i], busB_o[i]);
            end
        end
        tick();
        RegWr = 1'b0; Run = 1'b1;
        #1;
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (busA_o[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL run_suppress inst%0d r7=%h, required 0", i, busA_o[i]);
            end
        end
    endtask

    task automatic test_zero_reg();
        Run = 1'b1; Overflow = 1'b0; RegDst = 1'b1; Rd = 5'd0; Rs = 5'd0; Rt = 5'd0;
        busW = 32'hFFFFFFFF; RegWr = 1'b1;
        #1;
        vectors++;
        if (busA_o[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_reg_same_cycle busA=%h, required 0", busA_o[2]);
        end
        vectors++;
        if (busA_o[0] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL r0_normal_bypass busA=%h, required ffffffff", busA_o[0]);
        end
        tick();
        RegWr = 1'b0;
        #1;
        vectors++;
        if (busA_o[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_reg_next_cycle busA=%h, required 0", busA_o[2]);
        end
        Rd = 5'd1; busW = 32'h55AA_33CC; RegWr = 1'b1;
        tick();
        RegWr = 1'b0; Rs = 5'd1;
        #1;
        vectors++;
        if (busA_o[2] !== 32'h55AA_33CC) begin
            miscompares++;
            $display("FAIL zero_reg_r1_write busA=%h, required 55aa33cc", busA_o[2]);
        end
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 300; n++) begin
            Rs       = AW'($urandom_range(0, DEPTH - 1));
            Rt       = AW'($urandom_range(0, DEPTH - 1));
            Rd       = ($urandom_range(0, 3) == 0) ? Rs : AW'($urandom_range(0, DEPTH - 1));
            RegDst   = 1'($urandom_range(0, 1));
            RegWr    = ($urandom_range(0, 9) < 7);
            Overflow = ($urandom_range(0, 9) < 2);
            Run      = ($urandom_range(0, 9) < 8);
            busW     = $urandom;
            #1;
            for (int unsigned i = 0; i < NI; i++) begin
                vectors++;
                if (busA_o[i] !== m_rd(i, Rs) || busB_o[i] !== m_rd(i, Rt)) begin
                    miscompares++;
                    $display("FAIL random inst%0d step %0d: busA=%h busB=%h, required %h %h",
                             i, n, busA_o[i], busB_o[i], m_rd(i, Rs), m_rd(i, Rt));
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_sweep_reset();
        int unsigned n;
        Run = 1'b1; Overflow = 1'b0; RegDst = 1'b1; Rd = 5'd9; busW = 32'hCAFE0009; RegWr = 1'b1;
        tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            Rd   = AW'($urandom_range(0, DEPTH - 1));
            busW = $urandom;
            tick();
        end
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        n = 0;
        while (ready_o[0] !== 1'b1 && n < 100) begin
            Rd   = AW'($urandom_range(0, DEPTH - 1));
            busW = $urandom;
            tick();
            n++;
        end
        for (int unsigned i = 0; i < NI; i++) begin
            vectors++;
            if (n != DEPTH || ready_o[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_reset_latency inst%0d: edges=%0d Ready=%b, required %0d and 1",
                         i, n, ready_o[i], DEPTH);
            end
        end
        RegWr = 1'b0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            Rs = AW'(a);
            #1;
            for (int unsigned i = 0; i < NI; i++) begin
                vectors++;
                if (busA_o[i] !== '0) begin
                    miscompares++;
                    $display("FAIL clear_after_reset inst%0d r%0d: busA=%h, required 0",
                             i, a, busA_o[i]);
                end
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_ready = 1'b0; m_cnt = 0;
        Rst_n = 1'b0; Rs = '0; Rt = '0; Rd = '0; RegDst = 1'b0; RegWr = 1'b0;
        Overflow = 1'b0; Run = 1'b0; busW = '0;
        test_reset();
        test_write_readback();
        test_suppress();
        test_zero_reg();
        test_random();
        test_mid_sweep_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the single-cycle 32x32 register file: configurable width and depth, optional hardwired-zero register 0, and optional write-to-read bypass. After reset a sequencer sweeps every entry to zero and holds a `Ready` flag low until the sweep completes. It sits between the decode stage and the ALU/writeback path of the CPU datapath. It keeps the existing `RegDst` destination select, `Run` gating and `Overflow` write suppression.

## Interface
- `WIDTH`, 32: data width of each register and of `busA`/`busB`/`busW`.
- `DEPTH`, 32: number of registers; a power of two, at least 2.
- `AW`, `$clog2(DEPTH)`: register address width (derived).
- `ZERO_REG`, 0: when 1, register 0 always reads zero and writes to it are discarded.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to a matching read port.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: reset is synchronous and active-low.
- `Rs` in AW: read address A.
- `Rt` in AW: read address B; also write destination when `RegDst`=0.
- `Rd` in AW: write destination when `RegDst`=1.
- `RegDst` in 1: destination select, 0→`Rt`, 1→`Rd`.
- `RegWr` in 1: write request.
- `Overflow` in 1: ALU overflow; suppresses the write.
- `Run` in 1: CPU run enable; gates reads and writes.
- `busW` in WIDTH: write data.
- `busA` out WIDTH: read data A (combinational).
- `busB` out WIDTH: read data B (combinational).
- `Ready` out 1: high when the clear sweep is done and the file is usable.

## Operation
- Write destination: `Rw = RegDst ? Rd : Rt`.
- Write enable: `RealWr = RegWr & ~Overflow & Run & Ready & ~(ZERO_REG & (Rw==0))`.
  - When `RealWr` is high, `Mem[Rw] <= busW` on the rising edge.
- States:
  - **CLEAR**: sweep pointer `ptr`; writes `Mem[ptr] <= 0` each cycle.
  - **READY**: normal operation.
- State transitions:
  - `Rst_n`=0 on an edge: state ← CLEAR, `ptr` ← 0, `Ready` ← 0, whatever the current state.
  - CLEAR with `Rst_n`=1: clear `Mem[ptr]`, then `ptr` ← `ptr`+1.
  - When `ptr`==DEPTH-1, clear that entry and move to READY with `Ready` ← 1.
  - READY holds until the next reset.
- The array has no reset of its own; clearing happens only through the sweep.
- Read port A (port B is identical using `Rt`/`busB`):
  - `busA` = 0 when `Run`=0 or `Ready`=0.
  - Otherwise `busA` = 0 when `ZERO_REG` and `Rs`==0.
  - Otherwise, when `BYPASS` and `RealWr` and `Rw`==`Rs`, `busA` = `busW`.
  - Otherwise `busA` = `Mem[Rs]`.
- Boundary rules:
  - `RegWr` during CLEAR is dropped silently; it is not queued.
  - `Overflow`=1 suppresses the write but not the reads.
  - `Run`=0 in READY freezes the array contents. The sweep still runs during CLEAR regardless of `Run`.
  - Both read ports may address the same register, including the write target. Both get the bypassed value.
  - Wrap of `ptr` is not possible: the sweep stops at DEPTH-1.

## Timing
- Reset values:
  - `Ready`=0.
  - `busA`=`busB`=0, because reads are forced to zero while not ready.
  - state=CLEAR, `ptr`=0.
- Clear latency: the first edge with `Rst_n`=1 clears entry 0. `Ready` rises on the edge that clears entry DEPTH-1, i.e. after DEPTH edges with `Rst_n` high.
- A write is visible through the array on the cycle after its edge. With `BYPASS`=1 it is also visible combinationally in the same cycle. With `BYPASS`=0 the same-cycle read returns the old value.
- Reads are purely combinational from `Rs`/`Rt`/`Run`/`Ready`/write-port inputs. There is no read latency.
- Reset asserted mid-sweep restarts the sweep at entry 0. Entries already cleared stay zero.

## Test plan
- **Reset sweep:** hold `Rst_n`=0 for 2 cycles, then release (DEPTH=32).
  - `Ready` must be 0 for exactly 32 edges and 1 after.
  - Every register must then read 0 on `busA`.
- **Write/readback:** `RegDst`=1, `Rd`=5, `busW`=0xDEADBEEF, `RegWr`=1.
  - Next cycle, `Rs`=5 → `busA`=0xDEADBEEF.
  - Same-cycle `Rt`=5 with `BYPASS`=1 → `busB`=0xDEADBEEF.
  - With `BYPASS`=0 → `busB`=0.
- **Suppression:**
  - Write 0x1234 to `Rt`=7 with `Overflow`=1 → r7 stays 0.
  - Repeat with `Run`=0 → r7 stays 0 and `busA`/`busB`=0.
  - `RegWr`=1 during CLEAR → no register changes after `Ready` rises.
- **ZERO_REG=1:** write 0xFFFFFFFF to r0.
  - `busA` with `Rs`=0 must read 0 in the write cycle and the next cycle.
  - Writing r1 still works.
- **Reset mid-sweep:** release `Rst_n`, then reassert it after 10 cycles, then release again.
  - `Ready` must rise exactly 32 edges after the second release.
  - A value written before the first reset must read 0.
